// File: rtl/masked_hpc3_mul_arbiter_pkg.sv
// Shared helpers for the masked HPC3 multiplier arbiter: randomness sizing,
// share-pair indexing and one-hot / round-robin utilities.
package masked_hpc3_mul_arbiter_pkg;

  localparam int MAX_REQ   = 8;
  localparam int MAX_REQ_W = 3;

  typedef logic [MAX_REQ-1:0] req_vec_t;

  function automatic int num_quad(input int num_shares);
    return num_shares * (num_shares - 1) / 2;
  endfunction

  // Position of the unordered share pair {i, j} inside the r/p word vectors.
  function automatic int pair_idx(input int i, input int j, input int num_shares);
    int lo;
    int hi;
    int idx;
    lo  = (i < j) ? i : j;
    hi  = (i < j) ? j : i;
    idx = 0;
    for (int a = 0; a < num_shares; a++) begin
      if (a < lo) idx += num_shares - 1 - a;
    end
    return idx + (hi - lo - 1);
  endfunction

  function automatic req_vec_t onehot(input int idx);
    return req_vec_t'(1) << idx;
  endfunction

  function automatic int onehot_idx(input req_vec_t vec);
    int idx;
    idx = 0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (vec[k]) idx = k;
    end
    return idx;
  endfunction

  // First valid requester at or after ptr, wrapping modulo num_req.
  function automatic req_vec_t rr_grant(input req_vec_t valid, input int ptr, input int num_req);
    req_vec_t grant;
    logic     found;
    int       idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (ptr + k) % num_req;
      if (k < num_req && !found && valid[idx[MAX_REQ_W-1:0]]) begin
        grant = onehot(idx);
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/masked_hpc3_1_mul.sv
// First-order-and-up HPC3 masked AND gadget: one register stage, output shares
// are the XOR of registered partial products per share index.
module masked_hpc3_1_mul
  import masked_hpc3_mul_arbiter_pkg::*;
#(
  parameter  int NUM_SHARES    = 2,
  parameter  int BIT_WIDTH     = 4,
  localparam int NUM_QUADRATIC = num_quad(NUM_SHARES)
) (
  input  logic                                     in_clock,
  input  logic                                     in_reset,
  input  logic                                     in_enable,
  input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]    in_a,
  input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]    in_b,
  input  logic [NUM_QUADRATIC-1:0][BIT_WIDTH-1:0] in_r,
  input  logic [NUM_QUADRATIC-1:0][BIT_WIDTH-1:0] in_p,
  output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]    out_c
);

  logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] mul_d;
  logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] mul_q;
  logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] blind_d;
  logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] blind_q;

  // Cross terms are re-randomised by r (shared by the pair) and blinded by p
  // before the register so no share combination reaches a wire unmasked.
  always_comb begin
    mul_d   = mul_q;
    blind_d = blind_q;
    if (in_enable) begin
      for (int i = 0; i < NUM_SHARES; i++) begin
        for (int j = 0; j < NUM_SHARES; j++) begin
          if (i == j) begin
            mul_d[i][j]   = in_a[i] & in_b[i];
            blind_d[i][j] = '0;
          end else begin
            mul_d[i][j]   = in_a[i] & (in_b[j] ^ in_r[pair_idx(i, j, NUM_SHARES)]);
            blind_d[i][j] = (~in_a[i] & in_r[pair_idx(i, j, NUM_SHARES)])
                            ^ in_p[pair_idx(i, j, NUM_SHARES)];
          end
        end
      end
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      mul_q   <= '0;
      blind_q <= '0;
    end else begin
      mul_q   <= mul_d;
      blind_q <= blind_d;
    end
  end

  always_comb begin
    out_c = '0;
    for (int i = 0; i < NUM_SHARES; i++) begin
      for (int j = 0; j < NUM_SHARES; j++) begin
        out_c[i] = out_c[i] ^ mul_q[i][j] ^ blind_q[i][j];
      end
    end
  end

endmodule

// File: rtl/masked_hpc3_mul_arbiter_rr_arbiter.sv
// Round-robin grant generator; the pointer advances past the winner on accept.
module rr_arbiter
  import masked_hpc3_mul_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               in_clock,
  input  logic               in_reset,
  input  logic [NUM_REQ-1:0] in_valid,
  output logic [NUM_REQ-1:0] out_grant,
  input  logic               in_accept
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] rr_ptr_d;
  logic [PTR_W-1:0] rr_ptr_q;
  req_vec_t         valid_ext;
  req_vec_t         grant_ext;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = in_valid;
    grant_ext                = in_reset ? '0 : rr_grant(valid_ext, int'(rr_ptr_q), NUM_REQ);
    out_grant                = grant_ext[NUM_REQ-1:0];
    rr_ptr_d                 = rr_ptr_q;
    if (in_accept) rr_ptr_d  = PTR_W'((onehot_idx(grant_ext) + 1) % NUM_REQ);
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/register.sv
// Generic enabled register with synchronous active-high clear.
module register #(
  parameter int WIDTH = 1
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic             in_enable,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (in_enable) data_d = in_data;
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) data_q <= '0;
    else          data_q <= data_d;
  end

  assign out_data = data_q;

endmodule

// File: rtl/masked_hpc3_mul_arbiter.sv
// Shares one HPC3 masked AND gadget between NUM_REQ requesters: arbitrate,
// stage operands (S1), run the gadget, and steer the product back (S2).
module masked_hpc3_mul_arbiter
  import masked_hpc3_mul_arbiter_pkg::*;
#(
  parameter  int NUM_SHARES    = 2,
  parameter  int BIT_WIDTH     = 4,
  parameter  int NUM_REQ       = 2,
  localparam int NUM_QUADRATIC = num_quad(NUM_SHARES)
) (
  input  logic                                                  in_clock,
  input  logic                                                  in_reset,
  input  logic [NUM_REQ-1:0]                                    in_req_valid,
  output logic [NUM_REQ-1:0]                                    out_req_ready,
  input  logic [NUM_REQ-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0]     in_req_a,
  input  logic [NUM_REQ-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0]     in_req_b,
  input  logic [NUM_QUADRATIC-1:0][BIT_WIDTH-1:0]               in_r,
  input  logic [NUM_QUADRATIC-1:0][BIT_WIDTH-1:0]               in_p,
  output logic                                                  out_rand_take,
  output logic [NUM_REQ-1:0]                                    out_rsp_valid,
  output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                  out_rsp_c,
  output logic                                                  out_busy
);

  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int OP_W  = NUM_SHARES * BIT_WIDTH;

  logic [NUM_REQ-1:0]                  grant;
  req_vec_t                            grant_ext;
  logic [TAG_W-1:0]                    grant_idx;
  logic                                accept;
  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] s1_early_d;
  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] s1_early_q;
  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] s1_late_d;
  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] s1_late_q;
  logic [TAG_W-1:0]                    tag1_d;
  logic [TAG_W-1:0]                    tag1_q;
  logic [TAG_W-1:0]                    tag2_q;
  logic                                v1_d;
  logic                                v1_q;
  logic                                v2_q;
  logic                                rand_take;
  logic                                rsp_live;
  logic [NUM_QUADRATIC-1:0][BIT_WIDTH-1:0] gad_r;
  logic [NUM_QUADRATIC-1:0][BIT_WIDTH-1:0] gad_p;
  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] gad_c;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .in_clock  (in_clock),
    .in_reset  (in_reset),
    .in_valid  (in_req_valid),
    .out_grant (grant),
    .in_accept (accept)
  );

  assign out_req_ready = grant;

  // The b operand is the gadget's early input, a the late one.
  always_comb begin
    grant_ext              = '0;
    grant_ext[NUM_REQ-1:0] = grant;
    grant_idx              = TAG_W'(onehot_idx(grant_ext));
    accept                 = |(in_req_valid & grant);
    s1_early_d             = in_req_b[grant_idx];
    s1_late_d              = in_req_a[grant_idx];
    tag1_d                 = grant_idx;
    v1_d                   = accept;
  end

  register #(.WIDTH(OP_W)) u_s1_early (
    .in_clock (in_clock), .in_reset (in_reset), .in_enable (accept),
    .in_data  (s1_early_d), .out_data (s1_early_q)
  );

  register #(.WIDTH(OP_W)) u_s1_late (
    .in_clock (in_clock), .in_reset (in_reset), .in_enable (accept),
    .in_data  (s1_late_d), .out_data (s1_late_q)
  );

  register #(.WIDTH(TAG_W)) u_s1_tag (
    .in_clock (in_clock), .in_reset (in_reset), .in_enable (accept),
    .in_data  (tag1_d), .out_data (tag1_q)
  );

  register #(.WIDTH(1)) u_s1_valid (
    .in_clock (in_clock), .in_reset (in_reset), .in_enable (1'b1),
    .in_data  (v1_d), .out_data (v1_q)
  );

  register #(.WIDTH(TAG_W)) u_s2_tag (
    .in_clock (in_clock), .in_reset (in_reset), .in_enable (1'b1),
    .in_data  (tag1_q), .out_data (tag2_q)
  );

  register #(.WIDTH(1)) u_s2_valid (
    .in_clock (in_clock), .in_reset (in_reset), .in_enable (1'b1),
    .in_data  (v1_q), .out_data (v2_q)
  );

  // Randomness is only consumed (and only reaches the gadget) on a live take.
  always_comb begin
    rand_take = v1_q & ~in_reset;
    gad_r     = rand_take ? in_r : '0;
    gad_p     = rand_take ? in_p : '0;
  end

  masked_hpc3_1_mul #(.NUM_SHARES(NUM_SHARES), .BIT_WIDTH(BIT_WIDTH)) u_mul (
    .in_clock  (in_clock),
    .in_reset  (in_reset),
    .in_enable (rand_take),
    .in_a      (s1_early_q),
    .in_b      (s1_late_q),
    .in_r      (gad_r),
    .in_p      (gad_p),
    .out_c     (gad_c)
  );

  always_comb begin
    rsp_live      = v2_q & ~in_reset;
    out_rand_take = rand_take;
    out_rsp_c     = rsp_live ? gad_c : '0;
    out_busy      = (v1_q | v2_q) & ~in_reset;
    out_rsp_valid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      out_rsp_valid[k] = rsp_live && (int'(tag2_q) == k);
    end
  end

endmodule

// File: tb/tb_masked_hpc3_mul_arbiter.sv
// Randomised self-checking bench: a cycle-indexed schedule model predicts
// grants, randomness takes, response strobes and unmasked products.
module tb_masked_hpc3_mul_arbiter;
  import masked_hpc3_mul_arbiter_pkg::*;

  localparam int NS    = 2;
  localparam int BW    = 4;
  localparam int NR    = 2;
  localparam int NQ    = num_quad(NS);
  localparam int DEPTH = 1024;

  logic                        in_clock = 1'b0;
  logic                        in_reset;
  logic [NR-1:0]               req_valid;
  logic [NR-1:0]               req_ready;
  logic [NR-1:0][NS-1:0][BW-1:0] req_a;
  logic [NR-1:0][NS-1:0][BW-1:0] req_b;
  logic [NQ-1:0][BW-1:0]       rnd_r;
  logic [NQ-1:0][BW-1:0]       rnd_p;
  logic                        rand_take;
  logic [NR-1:0]               rsp_valid;
  logic [NS-1:0][BW-1:0]       rsp_c;
  logic                        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mdl_ptr = 0;
  int rsp_cnt = 0;
  int take_cnt = 0;

  logic [NR-1:0] sch_v    [DEPTH];
  logic [BW-1:0] sch_val  [DEPTH];
  logic          sch_take [DEPTH];

  logic                  fix_en = 1'b0;
  logic [NQ-1:0][BW-1:0] fix_r;
  logic [NQ-1:0][BW-1:0] fix_p;

  logic [NR-1:0]         obs_ready;
  logic [NR-1:0]         obs_rsp_v;
  logic                  obs_take;
  logic [NS-1:0][BW-1:0] obs_c;

  masked_hpc3_mul_arbiter #(.NUM_SHARES(NS), .BIT_WIDTH(BW), .NUM_REQ(NR)) dut (
    .in_clock      (in_clock),
    .in_reset      (in_reset),
    .in_req_valid  (req_valid),
    .out_req_ready (req_ready),
    .in_req_a      (req_a),
    .in_req_b      (req_b),
    .in_r          (rnd_r),
    .in_p          (rnd_p),
    .out_rand_take (rand_take),
    .out_rsp_valid (rsp_valid),
    .out_rsp_c     (rsp_c),
    .out_busy      (busy)
  );

  always #5 in_clock = ~in_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [BW-1:0] xs(input logic [NS-1:0][BW-1:0] v);
    logic [BW-1:0] acc;
    acc = '0;
    for (int s = 0; s < NS; s++) acc ^= v[s];
    return acc;
  endfunction

  // Random share split of unmasked values a_val / b_val for requester r.
  task automatic load(input int r, input logic [BW-1:0] a_val, input logic [BW-1:0] b_val);
    logic [BW-1:0] acc_a;
    logic [BW-1:0] acc_b;
    acc_a = a_val;
    acc_b = b_val;
    for (int s = 1; s < NS; s++) begin
      req_a[r][s] = BW'($urandom);
      req_b[r][s] = BW'($urandom);
      acc_a ^= req_a[r][s];
      acc_b ^= req_b[r][s];
    end
    req_a[r][0] = acc_a;
    req_b[r][0] = acc_b;
  endtask

  // One clock cycle: sample and check at negedge, then advance past posedge.
  task automatic tick();
    int            sel;
    int            idx;
    logic [NR-1:0] g;
    logic          exp_take;
    logic [NR-1:0] exp_v;
    if (cyc + 3 >= DEPTH) begin
      $display("FAIL cycle_budget got=%0d expected<%0d", cyc, DEPTH - 3);
      $fatal(1, "cycle budget exhausted");
    end
    @(negedge in_clock);
    obs_ready = req_ready;
    obs_take  = rand_take;
    obs_rsp_v = rsp_valid;
    obs_c     = rsp_c;
    if (rsp_valid != '0) begin
      rsp_cnt++;
      $display("cyc %0d rsp %b shares=%h xor=%h", cyc, rsp_valid, rsp_c, xs(rsp_c));
    end
    if (rand_take) take_cnt++;
    g   = '0;
    sel = -1;
    if (in_reset) begin
      mdl_ptr          = 0;
      sch_v[cyc+1]     = '0;
      sch_take[cyc+1]  = 1'b0;
      sch_v[cyc+2]     = '0;
      exp_take         = 1'b0;
      exp_v            = '0;
      check("rst_rsp_c", rsp_c, 0);
    end else begin
      for (int k = 0; k < NR; k++) begin
        idx = (mdl_ptr + k) % NR;
        if (sel < 0 && req_valid[idx]) sel = idx;
      end
      exp_take = sch_take[cyc];
      exp_v    = sch_v[cyc];
      if (sel >= 0) begin
        g[sel]          = 1'b1;
        sch_take[cyc+1] = 1'b1;
        sch_v[cyc+2]    = g;
        sch_val[cyc+2]  = xs(req_a[sel]) & xs(req_b[sel]);
        mdl_ptr         = (sel + 1) % NR;
      end
    end
    check("ready", req_ready, g);
    check("rand_take", rand_take, exp_take);
    check("rsp_valid", rsp_valid, exp_v);
    check("busy", busy, exp_take | (exp_v != '0));
    if (exp_v != '0) check("product", xs(rsp_c), sch_val[cyc]);
    @(posedge in_clock);
    #1;
    cyc++;
    for (int q = 0; q < NQ; q++) begin
      rnd_r[q] = fix_en ? fix_r[q] : BW'($urandom);
      rnd_p[q] = fix_en ? fix_p[q] : BW'($urandom);
    end
  endtask

  initial begin
    logic [NS-1:0][BW-1:0] c1;
    logic [NS-1:0][BW-1:0] c2;
    logic [NS-1:0][BW-1:0] c3;
    int base_rsp;
    int base_take;

    in_reset  = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rnd_r     = '0;
    rnd_p     = '0;
    fix_r     = '0;
    fix_p     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sch_v[i]    = '0;
      sch_val[i]  = '0;
      sch_take[i] = 1'b0;
    end
    repeat (3) tick();
    in_reset = 1'b0;

    // Single request: a=(3,5)=6, b=(1,3)=2 -> 2
    req_a[0][0] = 4'h3; req_a[0][1] = 4'h5;
    req_b[0][0] = 4'h1; req_b[0][1] = 4'h3;
    req_valid = 2'b01;
    tick();
    check("single_grant", obs_ready, 1);
    req_valid = '0;
    tick();
    check("single_take", obs_take, 1);
    tick();
    check("single_rsp_valid", obs_rsp_v, 1);
    check("single_product", xs(obs_c), 2);
    tick();

    // Contention straight out of reset
    in_reset = 1'b1;
    tick();
    in_reset = 1'b0;
    load(0, 4'hA, 4'h7);
    req_a[1][0] = 4'h6; req_a[1][1] = 4'h9;
    req_b[1][0] = 4'h3; req_b[1][1] = 4'hA;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("cont_grant", obs_ready, (k % 2 == 0) ? 1 : 2);
      if (k >= 2) check("cont_rsp_tag", obs_rsp_v, (k % 2 == 0) ? 1 : 2);
      if (k == 3) check("cont_req1_product", xs(obs_c), 9);
    end
    req_valid = '0;
    repeat (2) tick();

    // Requester 1 streams 8 back-to-back products
    base_rsp  = rsp_cnt;
    base_take = take_cnt;
    req_valid = 2'b10;
    for (int k = 0; k < 8; k++) begin
      load(1, BW'($urandom), BW'($urandom));
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
    check("pipe_rsp_count", rsp_cnt - base_rsp, 8);
    check("pipe_take_count", take_cnt - base_take, 8);

    // Reset one cycle after an accept
    load(0, BW'($urandom), BW'($urandom));
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    in_reset  = 1'b1;
    base_rsp  = rsp_cnt;
    tick();
    in_reset = 1'b0;
    repeat (2) tick();
    check("rst_flight_rsp_count", rsp_cnt - base_rsp, 0);
    req_valid = 2'b11;
    tick();
    check("rst_ptr_grant", obs_ready, 1);
    req_valid = '0;
    repeat (3) tick();

    // Idle gaps on requester 0
    for (int k = 0; k < 12; k++) begin
      req_valid = (k % 2 == 0) ? 2'b01 : 2'b00;
      load(0, BW'($urandom), BW'($urandom));
      tick();
    end
    req_valid = '0;
    repeat (2) tick();

    // Masking: same value, different splits and randomness
    fix_en = 1'b1;
    for (int q = 0; q < NQ; q++) fix_r[q] = 4'h5;
    for (int q = 0; q < NQ; q++) fix_p[q] = 4'h3;
    req_a[0][0] = 4'h3; req_a[0][1] = 4'h5;
    req_b[0][0] = 4'h9; req_b[0][1] = 4'hB;
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    tick();
    tick();
    c1 = obs_c;
    for (int q = 0; q < NQ; q++) fix_p[q] = 4'hC;
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    tick();
    tick();
    c2 = obs_c;
    for (int q = 0; q < NQ; q++) fix_p[q] = 4'h6;
    req_a[0][0] = 4'hE; req_a[0][1] = 4'h8;
    req_b[0][0] = 4'h4; req_b[0][1] = 4'h6;
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    tick();
    tick();
    c3 = obs_c;
    fix_en = 1'b0;
    check("mask_product_a", xs(c1), 2);
    check("mask_product_equal", xs(c3), xs(c1));
    check("mask_shares_differ", c1 != c2, 1);
    tick();

    // Random soak with occasional mid-flight resets
    for (int k = 0; k < 300; k++) begin
      req_valid = NR'($urandom);
      for (int r = 0; r < NR; r++) load(r, BW'($urandom), BW'($urandom));
      in_reset = ($urandom_range(0, 49) == 0);
      tick();
    end
    in_reset  = 1'b0;
    req_valid = '0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/masked_hpc3_mul_arbiter.md
# masked_hpc3_mul_arbiter

Round-robin arbiter and sequencer that shares one `masked_hpc3_1_mul` gadget between `NUM_REQ` requesters of masked bitwise-AND products. It runs the gadget fully pipelined at one issue per cycle. Per accepted request it:
- stages the operands in the gadget's early/late order;
- consumes one fresh randomness word and signals the randomness source;
- routes each product back to the requester that issued it.

It sits between the masked S-box/test datapaths and the shared multiplier, replacing duplicated gadgets in area-optimised configurations.

## Interface
Parameters:
- `NUM_SHARES`, default 2: number of Boolean shares per operand.
- `BIT_WIDTH`, default 4: bits per share; lanes are independent.
- `NUM_REQ`, default 2: number of requesters, 2..8.

Ports:
- `in_clock`  input  1  single clock, rising edge.
- `in_reset`  input  1  synchronous, active-high reset.
- `in_req_valid`  input  `NUM_REQ`  request pending per requester.
- `out_req_ready`  output  `NUM_REQ`  one-hot grant; the request is accepted when valid&ready.
- `in_req_a`  input  `NUM_REQ`×`NUM_SHARES`×`BIT_WIDTH`  late operand shares, per requester.
- `in_req_b`  input  `NUM_REQ`×`NUM_SHARES`×`BIT_WIDTH`  early operand shares, per requester.
- `in_r`  input  `NUM_QUADRATIC`×`BIT_WIDTH`  fresh randomness r.
- `in_p`  input  `NUM_QUADRATIC`×`BIT_WIDTH`  fresh randomness p.
- `out_rand_take`  output  1  high in the cycle `in_r`/`in_p` are consumed.
- `out_rsp_valid`  output  `NUM_REQ`  one-hot result strobe.
- `out_rsp_c`  output  `NUM_SHARES`×`BIT_WIDTH`  product shares; valid only with `out_rsp_valid`.
- `out_busy`  output  1  one or more products are in flight.

## Operation
- Arbitration:
  - Grant goes to the first valid requester at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - `out_req_ready` is combinational on `in_req_valid` and is never set for a non-valid requester.
  - After an accept by requester g, `rr_ptr` ← (g+1) mod `NUM_REQ`.
  - With no valid request, `rr_ptr` holds and no issue occurs.
- Stage S1, at the accept cycle edge, registers:
  - granted `in_req_b` → gadget `in_a` input;
  - granted `in_req_a` → late-operand register;
  - `tag1` = g, `v1` = 1.
- Gadget inputs:
  - The gadget's late input `in_b` is fed from the late-operand register.
  - Randomness `in_r`/`in_p` is sampled in the cycle with `v1`=1.
  - `out_rand_take` = `v1`. The source must present a new word on the cycle after each take.
- Stage S2: `tag2`/`v2` follow `tag1`/`v1` by one cycle. `out_rsp_valid` = `v2` ? onehot(`tag2`) : 0.
- Correctness: XOR of the `out_rsp_c` shares = (XOR of a-shares) AND (XOR of b-shares), per bit.
- Randomness: a word is never reused. When `v1`=0, the gadget's randomness inputs are driven to 0 and no take is signalled.
- Share hygiene: operand registers load only on accept. They hold their previous value otherwise, with no share recombination.
- `out_busy` = `v1` | `v2`.

## Timing
- Accept at cycle t → `out_rand_take` at t+1 → `out_rsp_valid`/`out_rsp_c` at t+2. Fixed latency of 2; no response backpressure.
- Throughput: one accept per cycle. Back-to-back accepts yield back-to-back responses in accept order.
- Simultaneous requests: exactly one is granted; losers keep valid asserted and are served in round-robin order.
- A single persistent requester is granted every cycle.
- Reset (synchronous, applies mid-operation):
  - `rr_ptr`=0; `v1`=`v2`=0; tags=0; operand and gadget state cleared to 0.
  - Outputs during and after reset: `out_req_ready`=0 while `in_reset`=1, `out_rsp_valid`=0, `out_rsp_c`=0, `out_rand_take`=0, `out_busy`=0.
  - In-flight products are discarded and no response is emitted for them.
- First accept is possible in the cycle after `in_reset` deasserts.

## Structure
- `num_quad()`, share-vector typedefs and a `onehot`/round-robin helper function belong in `aes128_package`.
- Reuse the `register` module for the S1/S2 pipeline.
- Instantiate exactly one `masked_hpc3_1_mul`.
- One sub-module is natural: `rr_arbiter` (parameter `NUM_REQ`; ports `in_valid`, `out_grant`, `in_accept`; holds `rr_ptr`).

## Test plan
Defaults: `NUM_SHARES`=2, `BIT_WIDTH`=4, `NUM_REQ`=2.
- Single request: requester 0 sends a=(3,5) [value 6] and b=(1,3) [value 2] at t. Expect `out_rand_take` at t+1; `out_rsp_valid`=01 at t+2 with share XOR = 2.
- Contention: both requesters valid for 4 cycles from reset. Grants are 0,1,0,1. Responses 2 cycles later carry matching tags and correct products (req1: a=0xF, b=0x9 → 0x9).
- Pipelining: requester 1 streams 8 back-to-back products with random shares. Expect 8 consecutive `out_rsp_valid`, 8 takes, every share XOR correct.
- Reset mid-flight: assert `in_reset` at t+1 after an accept at t. Expect no `out_rsp_valid` at t+2, all outputs 0, `rr_ptr`=0 afterwards.
- Idle gaps: alternate valid on/off on requester 0. Expect `out_rand_take` only on accept+1; `out_busy` high exactly during in-flight cycles.
- Masking check: same unmasked operands with different share splits and randomness. Expect identical share XOR and differing individual shares.
